// File: rtl/wall_spawner.sv
// Wall slot table: accepts clamped heights over valid/ready, scrolls walls left on frame ticks
// and retires them off-screen. Pass/score detection is built only when WALL_SPAWNER_SCORE_EN is defined.
module wall_spawner #(
    parameter int SCREEN_W  = 160,
    parameter int SPACING   = 40,
    parameter int SPEED     = 1,
    parameter int MAX_WALLS = 4,
    parameter int MIN_H     = 10,
    parameter int MAX_H     = 90,
    parameter int BIRD_X    = 20,
    localparam int IDX_W    = (MAX_WALLS > 1) ? $clog2(MAX_WALLS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             h_valid,
    input  logic [7:0]       h_data,
    output logic             h_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_active,
    output logic [7:0]       rd_x,
    output logic [7:0]       rd_h,
    output logic [IDX_W:0]   live_count,
    output logic [7:0]       score,
    output logic             score_pulse
);
    localparam logic [7:0] SCREEN_B  = 8'(SCREEN_W);
    localparam logic [7:0] SPACING_B = 8'(SPACING);
    localparam logic [7:0] SPEED_B   = 8'(SPEED);
    localparam logic [7:0] MIN_B     = 8'(MIN_H);
    localparam logic [7:0] MAX_B     = 8'(MAX_H);

    typedef enum logic [1:0] {IDLE, RUN, FETCH} state_t;

    state_t               state_reg, state_next;
    logic [MAX_WALLS-1:0] active_reg;
    logic [7:0]           x_reg [MAX_WALLS];
    logic [7:0]           h_reg [MAX_WALLS];
    logic [7:0]           gap_reg, gap_next;
    logic                 has_free;
    logic [IDX_W-1:0]     free_idx;
    logic                 xfer, scroll;
    logic [7:0]           h_clamped;
    logic [8:0]           gap_sum;

    assign h_ready   = (state_reg == FETCH) && enable;
    assign xfer      = h_valid && h_ready;
    assign scroll    = frame_tick && enable && (state_reg != IDLE);
    assign h_clamped = (h_data < MIN_B) ? MIN_B : ((h_data > MAX_B) ? MAX_B : h_data);
    assign gap_sum   = {1'b0, gap_reg} + {1'b0, SPEED_B};

    // Lowest-index free slot, taken from the current table so same-cycle retirements wait a cycle.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = MAX_WALLS - 1; i >= 0; i--) begin
            if (!active_reg[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        live_count = '0;
        for (int i = 0; i < MAX_WALLS; i++) begin
            live_count = live_count + {{IDX_W{1'b0}}, active_reg[i]};
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     if (gap_reg >= SPACING_B && has_free) state_next = FETCH;
                FETCH:   if (xfer) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        gap_next = gap_reg;
        if (xfer) begin
            gap_next = '0;
        end else if (scroll) begin
            gap_next = gap_sum[8] ? 8'hFF : gap_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            gap_reg   <= SPACING_B;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
        end
    end

    // A spawning slot is inactive this cycle, so it is never scrolled on its write cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_reg <= '0;
            for (int i = 0; i < MAX_WALLS; i++) begin
                x_reg[i] <= '0;
                h_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_WALLS; i++) begin
                if (xfer && free_idx == IDX_W'(i)) begin
                    active_reg[i] <= 1'b1;
                    x_reg[i]      <= SCREEN_B;
                    h_reg[i]      <= h_clamped;
                end else if (scroll && active_reg[i]) begin
                    if (x_reg[i] < SPEED_B) begin
                        active_reg[i] <= 1'b0;
                        x_reg[i]      <= '0;
                        h_reg[i]      <= '0;
                    end else begin
                        x_reg[i] <= x_reg[i] - SPEED_B;
                    end
                end
            end
        end
    end

    assign rd_active = active_reg[rd_idx];
    assign rd_x      = rd_active ? x_reg[rd_idx] : 8'd0;
    assign rd_h      = rd_active ? h_reg[rd_idx] : 8'd0;

`ifdef WALL_SPAWNER_SCORE_EN
    localparam logic [7:0] BIRD_B   = 8'(BIRD_X);
    localparam logic [8:0] PASS_LIM = 9'(BIRD_X + SPEED);

    logic [MAX_WALLS-1:0] crossing;
    logic [7:0]           score_reg;
    logic                 score_pulse_reg;

    // A wall passes when this scroll takes it from >= BIRD_X to below it (retirement included).
    for (genvar gi = 0; gi < MAX_WALLS; gi++) begin : g_cross
        assign crossing[gi] = active_reg[gi] && (x_reg[gi] >= BIRD_B) && ({1'b0, x_reg[gi]} < PASS_LIM);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_reg       <= '0;
            score_pulse_reg <= 1'b0;
        end else begin
            score_pulse_reg <= scroll && (|crossing);
            if (scroll && (|crossing)) begin
                score_reg <= score_reg + 8'd1;
            end
        end
    end

    assign score       = score_reg;
    assign score_pulse = score_pulse_reg;
`else
    assign score       = '0;
    assign score_pulse = 1'b0;
`endif

endmodule
